piso4_coef: RTL and testbench
=============================

Name: piso4_coef

Overview:
- Parallel-in serial-out converter for 12-bit polynomial coefficients; the transmit-side counterpart of the 7-stage serial-in parallel-out coefficient window.
- Accepts one beat of NW packed coefficients and emits them one per cycle on a serial stream, with valid/ready handshakes on both sides.
- A one-beat holding buffer sustains continuous 1 coefficient/cycle throughput.
- Sits between the butterfly/NTT datapath packers and the per-coefficient consumers (compress, encode, BRAM writer).

Parameters:
- IWID, 12, coefficient width in bits.
- NW, 4, coefficients per parallel beat.
- CNTW, 2, word-counter width; must satisfy 2**CNTW >= NW.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous reset, active-high.
- pdi  input  IWID*NW  parallel beat; slice [IWID*NW-1 -: IWID] is word 0 (oldest).
- pvalid  input  1  pdi valid.
- pready  output  1  beat accepted when pvalid && pready.
- sdo  output  IWID  serial coefficient.
- svalid  output  1  sdo valid.
- sready  input  1  consumer accepts sdo when svalid && sready.
- busy  output  1  high while any coefficient is held (shift register or buffer).

Behaviour:
- Reset decision: reset rst, synchronous, active-high; clock clk. All state clears on the rst clock edge, including mid-beat. Reset values: svalid=0, sdo=0, busy=0, counter=0, buffer empty, state IDLE. pready=1 from the first cycle after reset.
- Storage: shift register SR of NW words, word counter cnt (0..NW-1), and holding buffer HB (NW words) with flag hbv.
- Handshake:
  - pready = !hbv (combinational from state only; no dependence on pvalid).
  - svalid and sdo are registered.
- State machine:
  - IDLE: SR empty.
    - On pvalid && pready: load SR with pdi, set cnt=0, go to SHIFT.
    - sdo = word 0 and svalid=1 on the next cycle, giving latency 1 cycle.
  - SHIFT: sdo = SR word cnt.
    - Serial fire (svalid && sready) with cnt<NW-1: cnt+1, next word presented next cycle.
    - Serial fire with cnt==NW-1 (last word):
      - If hbv: SR<=HB, hbv<=0, cnt=0, stay in SHIFT.
      - Else if a parallel fire occurs in the same cycle: SR<=pdi, cnt=0, stay in SHIFT (bypass, no bubble).
      - Else go to IDLE with svalid=0.
    - Parallel fire in SHIFT not consumed by the bypass: HB<=pdi, hbv<=1.
- Back-pressure: sready=0 holds sdo, svalid and cnt stable. svalid never drops without a fire.
- Ordering: coefficients leave strictly in arrival order. Within a beat, word 0 (MSB slice) goes first and word NW-1 last. This round-trips through the SIPO window unchanged.
- busy = (state==SHIFT) || hbv.
- Simultaneous events:
  - Parallel and serial fire in the same cycle are legal in every state.
  - Last-word fire + HB full + new pvalid: pready was 0, so no capture occurs; pready rises the next cycle.
- No combinational path from pvalid to pready, or from sready to svalid.

Optional Feature:
- Macro: PISO4_COEF_LAST_EN.
- When defined:
  - Adds output slast (1 bit) and parameter NBEAT, default 64 (256 coefficients / NW).
  - A beat counter increments on each completed beat, i.e. a serial fire of word NW-1.
  - slast=1 coincident with svalid on word NW-1 of beat NBEAT-1; the beat counter then wraps to 0.
  - Reset clears the beat counter.
- When undefined: no slast port and no beat counter; all other behaviour is identical.

Test Plan:
- Single beat: after reset, pdi=0x123_456_789_ABC (words 0x123,0x456,0x789,0xABC), pvalid for 1 cycle, sready=1 → svalid 1 cycle later; sdo=0x123,0x456,0x789,0xABC on 4 consecutive cycles; busy falls after the 4th; pready=1 throughout.
- Streaming: pvalid held high with 3 beats (0x001..0x00C), sready=1 → 12 contiguous svalid cycles with sdo=0x001..0x00C in order; pready low only when HB is full.
- Back-pressure: sready=0 for 5 cycles while showing word 1 (0x456) → sdo stays 0x456 and svalid stays 1; second beat held in HB; pready=0 until HB drains.
- Bypass edge: SR at cnt=3, HB empty, last-word fire coincident with new beat 0xFFF_000_AAA_555 → next cycle sdo=0xFFF with no svalid gap; hbv stays 0.
- Reset mid-operation: assert rst while cnt=2 and HB full → next cycle svalid=0, busy=0, pready=1; the next beat emits its word 0 first.
- With PISO4_COEF_LAST_EN, NBEAT=2: stream 2 beats → slast=1 only on the 8th coefficient; a 3rd beat's 4th coefficient has slast=0.

Source files
------------

// File: rtl/piso4_coef_if.sv
// Handshake bundle for the coefficient PISO: parallel beat in, serial coefficients out.
// Build with PISO4_COEF_LAST_EN to add the end-of-block flag slast.
interface piso4_coef_if #(
  parameter int IWID = 12,
  parameter int NW   = 4
);
  logic [IWID*NW-1:0] pdi;
  logic               pvalid;
  logic               pready;
  logic [IWID-1:0]    sdo;
  logic               svalid;
  logic               sready;
  logic               busy;
`ifdef PISO4_COEF_LAST_EN
  logic               slast;
`endif

  // The converter itself is the slave; the producer/consumer side is the master.
  modport slave (
    input  pdi, pvalid, sready,
    output pready, sdo, svalid, busy
`ifdef PISO4_COEF_LAST_EN
    , output slast
`endif
  );

  modport master (
    output pdi, pvalid, sready,
    input  pready, sdo, svalid, busy
`ifdef PISO4_COEF_LAST_EN
    , input slast
`endif
  );
endinterface

// File: rtl/piso4_coef.sv
// Parallel-in serial-out converter: one beat of NW coefficients out, word 0 first, with a
// one-beat holding buffer for 1 coefficient/cycle streaming. PISO4_COEF_LAST_EN adds slast.
module piso4_coef #(
  parameter int IWID = 12,
  parameter int NW   = 4,
  parameter int CNTW = 2
`ifdef PISO4_COEF_LAST_EN
  , parameter int NBEAT = 64
`endif
) (
  input logic        clk,
  input logic        rst,
  piso4_coef_if.slave bus
);
  typedef enum logic {IDLE, SHIFT} state_t;

  state_t          state_reg;
  logic [IWID-1:0] sr_reg [NW];
  logic [IWID-1:0] hb_reg [NW];
  logic            hbv_reg;
  logic [CNTW-1:0] cnt_reg;
  logic [IWID-1:0] sdo_reg;
  logic            svalid_reg;
  logic [IWID-1:0] pdi_word [NW];

  for (genvar gi = 0; gi < NW; gi++) begin : g_unpack
    assign pdi_word[gi] = bus.pdi[IWID*(NW-gi)-1 -: IWID];
  end

  logic            pfire;
  logic            sfire;
  logic            last_word;
  logic [CNTW-1:0] cnt_inc;

  assign pfire     = bus.pvalid && !hbv_reg;
  assign sfire     = svalid_reg && bus.sready;
  assign last_word = (cnt_reg == CNTW'(NW-1));
  assign cnt_inc   = cnt_reg + 1'b1;

`ifdef PISO4_COEF_LAST_EN
  localparam int BW = (NBEAT > 1) ? $clog2(NBEAT) : 1;
  logic [BW-1:0] beat_reg;
  logic [BW-1:0] beat_wrap;
  logic          slast_reg;
  logic          beat_is_last;
  logic          wrap_is_last;

  assign beat_wrap    = (beat_reg == BW'(NBEAT-1)) ? '0 : beat_reg + 1'b1;
  assign beat_is_last = (beat_reg == BW'(NBEAT-1));
  assign wrap_is_last = (beat_wrap == BW'(NBEAT-1));
  assign bus.slast    = slast_reg;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      hbv_reg    <= 1'b0;
      cnt_reg    <= '0;
      sdo_reg    <= '0;
      svalid_reg <= 1'b0;
      for (int i = 0; i < NW; i++) begin
        sr_reg[i] <= '0;
        hb_reg[i] <= '0;
      end
`ifdef PISO4_COEF_LAST_EN
      beat_reg  <= '0;
      slast_reg <= 1'b0;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          if (pfire) begin
            for (int i = 0; i < NW; i++) sr_reg[i] <= pdi_word[i];
            cnt_reg    <= '0;
            sdo_reg    <= pdi_word[0];
            svalid_reg <= 1'b1;
            state_reg  <= SHIFT;
`ifdef PISO4_COEF_LAST_EN
            slast_reg  <= (NW == 1) && beat_is_last;
`endif
          end
        end
        SHIFT: begin
          if (sfire && !last_word) begin
            cnt_reg <= cnt_inc;
            sdo_reg <= sr_reg[cnt_inc];
`ifdef PISO4_COEF_LAST_EN
            slast_reg <= (cnt_inc == CNTW'(NW-1)) && beat_is_last;
`endif
          end else if (sfire) begin
`ifdef PISO4_COEF_LAST_EN
            beat_reg  <= beat_wrap;
            slast_reg <= (NW == 1) && wrap_is_last;
`endif
            // Last word leaving: refill from the buffer first, else bypass a fresh beat.
            if (hbv_reg) begin
              for (int i = 0; i < NW; i++) sr_reg[i] <= hb_reg[i];
              hbv_reg <= 1'b0;
              cnt_reg <= '0;
              sdo_reg <= hb_reg[0];
            end else if (pfire) begin
              for (int i = 0; i < NW; i++) sr_reg[i] <= pdi_word[i];
              cnt_reg <= '0;
              sdo_reg <= pdi_word[0];
            end else begin
              svalid_reg <= 1'b0;
              state_reg  <= IDLE;
`ifdef PISO4_COEF_LAST_EN
              slast_reg  <= 1'b0;
`endif
            end
          end
          // A beat arriving while the shifter is busy parks in the holding buffer.
          if (pfire && !(sfire && last_word)) begin
            for (int i = 0; i < NW; i++) hb_reg[i] <= pdi_word[i];
            hbv_reg <= 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.pready = !hbv_reg;
  assign bus.sdo    = sdo_reg;
  assign bus.svalid = svalid_reg;
  assign bus.busy   = (state_reg == SHIFT) || hbv_reg;
endmodule

// File: tb/tb_piso4_coef.sv
// Directed bench for piso4_coef: streaming, single beat, back-pressure, bypass, mid-beat reset.
module tb_piso4_coef;
  logic clk = 1'b0;
  logic rst;
  int   compared = 0;
  int   mismatched = 0;

  always #5 clk = ~clk;

  piso4_coef_if #(.IWID(12), .NW(4)) bus ();

`ifdef PISO4_COEF_LAST_EN
  piso4_coef #(.IWID(12), .NW(4), .CNTW(2), .NBEAT(2)) dut (.clk(clk), .rst(rst), .bus(bus));
`else
  piso4_coef #(.IWID(12), .NW(4), .CNTW(2)) dut (.clk(clk), .rst(rst), .bus(bus));
`endif

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  logic [47:0] beats [3];
  bit          exp_pr [12];
  logic [11:0] w_a [4];
  logic [11:0] w_tail [6];
  logic [11:0] w_byp [4];
  logic [11:0] w_rst [4];
  int          bi;
  bit          fire;

  initial begin
    beats  = '{48'h001002003004, 48'h005006007008, 48'h00900A00B00C};
    exp_pr = '{1, 0, 0, 0, 1, 0, 0, 0, 1, 1, 1, 1};
    w_a    = '{12'h123, 12'h456, 12'h789, 12'hABC};
    w_tail = '{12'h789, 12'hABC, 12'h111, 12'h222, 12'h333, 12'h444};
    w_byp  = '{12'hFFF, 12'h000, 12'hAAA, 12'h555};
    w_rst  = '{12'hABC, 12'hDEF, 12'h012, 12'h345};

    // Reset
    rst = 1'b1; bus.pvalid = 1'b0; bus.pdi = '0; bus.sready = 1'b0;
    step(); step();
    chk("rst_svalid", {47'd0, bus.svalid}, 48'd0);
    chk("rst_sdo", {36'd0, bus.sdo}, 48'd0);
    chk("rst_busy", {47'd0, bus.busy}, 48'd0);
    chk("rst_pready", {47'd0, bus.pready}, 48'd1);
    rst = 1'b0;
    step();

    // Streaming: three beats, pvalid held whenever a beat is pending
    bi = 0; bus.pdi = beats[0]; bus.pvalid = 1'b1; bus.sready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      fire = bus.pvalid && bus.pready;
      step();
      if (fire) begin
        bi++;
        if (bi < 3) bus.pdi = beats[bi];
        else bus.pvalid = 1'b0;
      end
      chk("stream_svalid", {47'd0, bus.svalid}, 48'd1);
      chk("stream_sdo", {36'd0, bus.sdo}, 48'(i + 1));
      chk("stream_pready", {47'd0, bus.pready}, {47'd0, exp_pr[i]});
`ifdef PISO4_COEF_LAST_EN
      chk("stream_slast", {47'd0, bus.slast}, {47'd0, (i == 7)});
`endif
    end
    step();
    chk("stream_end_svalid", {47'd0, bus.svalid}, 48'd0);
    chk("stream_end_busy", {47'd0, bus.busy}, 48'd0);

    // Single beat
    bus.pdi = 48'h123456789ABC; bus.pvalid = 1'b1;
    step();
    bus.pvalid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("single_svalid", {47'd0, bus.svalid}, 48'd1);
      chk("single_sdo", {36'd0, bus.sdo}, {36'd0, w_a[i]});
      chk("single_pready", {47'd0, bus.pready}, 48'd1);
      chk("single_busy", {47'd0, bus.busy}, 48'd1);
      step();
    end
    chk("single_end_svalid", {47'd0, bus.svalid}, 48'd0);
    chk("single_end_busy", {47'd0, bus.busy}, 48'd0);

    // Back-pressure on word 1 with a second beat parked in the buffer
    bus.pdi = 48'h123456789ABC; bus.pvalid = 1'b1;
    step();
    bus.pdi = 48'h111222333444;
    step();
    bus.pvalid = 1'b0; bus.sready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_sdo", {36'd0, bus.sdo}, 48'h456);
      chk("bp_svalid", {47'd0, bus.svalid}, 48'd1);
      chk("bp_pready", {47'd0, bus.pready}, 48'd0);
    end
    bus.sready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("bp_drain_sdo", {36'd0, bus.sdo}, {36'd0, w_tail[i]});
      chk("bp_drain_svalid", {47'd0, bus.svalid}, 48'd1);
    end
    step();
    chk("bp_end_svalid", {47'd0, bus.svalid}, 48'd0);

    // Bypass: new beat accepted on the last-word fire, no bubble
    bus.pdi = 48'h123456789ABC; bus.pvalid = 1'b1;
    step();
    bus.pvalid = 1'b0;
    step(); step(); step();
    chk("byp_pre_sdo", {36'd0, bus.sdo}, 48'hABC);
    bus.pdi = 48'hFFF000AAA555; bus.pvalid = 1'b1;
    step();
    bus.pvalid = 1'b0;
    chk("byp_pready", {47'd0, bus.pready}, 48'd1);
    for (int i = 0; i < 4; i++) begin
      chk("byp_sdo", {36'd0, bus.sdo}, {36'd0, w_byp[i]});
      chk("byp_svalid", {47'd0, bus.svalid}, 48'd1);
      step();
    end
    chk("byp_end_svalid", {47'd0, bus.svalid}, 48'd0);

    // Reset with cnt=2 and the buffer full
    bus.pdi = 48'h123456789ABC; bus.pvalid = 1'b1;
    step();
    bus.pdi = 48'h111222333444;
    step();
    bus.pvalid = 1'b0;
    step();
    chk("rmid_pre_sdo", {36'd0, bus.sdo}, 48'h789);
    chk("rmid_pre_pready", {47'd0, bus.pready}, 48'd0);
    rst = 1'b1;
    step();
    chk("rmid_svalid", {47'd0, bus.svalid}, 48'd0);
    chk("rmid_busy", {47'd0, bus.busy}, 48'd0);
    chk("rmid_pready", {47'd0, bus.pready}, 48'd1);
    rst = 1'b0;
    bus.pdi = 48'hABCDEF012345; bus.pvalid = 1'b1;
    step();
    bus.pvalid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("rmid_sdo", {36'd0, bus.sdo}, {36'd0, w_rst[i]});
      chk("rmid_svalid_run", {47'd0, bus.svalid}, 48'd1);
      step();
    end
    chk("rmid_end_svalid", {47'd0, bus.svalid}, 48'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
